// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding, frame constants and sizing helper.
// Rev 1.0
`default_nettype none

package program_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LEN_LO  = 4'd1,
      ST_LEN_HI  = 4'd2,
      ST_DATA_LO = 4'd3,
      ST_DATA_HI = 4'd4,
      ST_WRITE   = 4'd5,
      ST_CHECK   = 4'd6,
      ST_DONE    = 4'd7,
      ST_ERROR   = 4'd8
   } loader_state_e;

   localparam int LEN_BYTES     = 2;
   localparam int CHECKSUM_INIT = 0;

   // Largest image (in words) that fits an instruction memory of 2**addr_w words.
   function automatic logic [16:0] max_words(input int addr_w);
      return 17'(1) << addr_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// program_loader: assembles a length-prefixed, XOR-checked byte stream into 16-bit
// instruction words and writes them to instruction memory while holding the CPU. Rev 1.0
`default_nettype none

module program_loader
   import program_loader_pkg::*;
#(
   parameter int INST_W   = 16,
   parameter int I_ADDR_W = 12,
   parameter int BYTE_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [BYTE_W-1:0]   rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic                imem_write_enable,
   output logic [I_ADDR_W-1:0] imem_address,
   output logic [INST_W-1:0]   imem_write_data,
   output logic                cpu_hold,
   output logic                busy,
   output logic                done,
   output logic                error
);

   localparam int LEN_W = LEN_BYTES * BYTE_W;

   loader_state_e         state_q, state_d;
   logic [BYTE_W-1:0]     len_lo_q, len_lo_d;
   logic [BYTE_W-1:0]     lo_q, lo_d;
   logic [BYTE_W-1:0]     chk_q, chk_d;
   logic [LEN_W-1:0]      remain_q, remain_d;
   logic [I_ADDR_W-1:0]   addr_q, addr_d;
   logic [I_ADDR_W-1:0]   waddr_q, waddr_d;
   logic [INST_W-1:0]     wdata_q, wdata_d;
   logic                  hold_q, hold_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  accept;
   logic [LEN_W-1:0]      len_word;

   assign rx_ready = (state_q == ST_LEN_LO)  || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA_LO) || (state_q == ST_DATA_HI) ||
                     (state_q == ST_CHECK);
   assign accept   = rx_valid & rx_ready;
   assign len_word = {rx_data, len_lo_q};

   assign imem_write_enable = (state_q == ST_WRITE);
   assign imem_address      = waddr_q;
   assign imem_write_data   = wdata_q;
   assign cpu_hold          = hold_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign error             = error_q;

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      lo_d     = lo_q;
      chk_d    = chk_q;
      remain_d = remain_q;
      addr_d   = addr_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      hold_d   = hold_q;
      busy_d   = busy_q;
      done_d   = done_q;
      error_d  = error_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d  = ST_LEN_LO;
               done_d   = 1'b0;
               error_d  = 1'b0;
               remain_d = '0;
               chk_d    = BYTE_W'(CHECKSUM_INIT);
               addr_d   = '0;
               hold_d   = 1'b1;
               busy_d   = 1'b1;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               remain_d = len_word;
               if ({1'b0, len_word} > max_words(I_ADDR_W)) begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else if (len_word == '0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_DATA_LO;
               end
            end
         end
         ST_DATA_LO: begin
            if (accept) begin
               lo_d    = rx_data;
               chk_d   = chk_q ^ rx_data;
               state_d = ST_DATA_HI;
            end
         end
         ST_DATA_HI: begin
            if (accept) begin
               chk_d   = chk_q ^ rx_data;
               wdata_d = {rx_data, lo_q};
               waddr_d = addr_q;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // A 2**I_ADDR_W image wraps the counter here; nothing is written afterwards.
            addr_d   = addr_q + I_ADDR_W'(1);
            remain_d = remain_q - LEN_W'(1);
            state_d  = (remain_q == LEN_W'(1)) ? ST_CHECK : ST_DATA_LO;
         end
         ST_CHECK: begin
            if (accept) begin
               busy_d = 1'b0;
               if (rx_data == chk_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         len_lo_q <= '0;
         lo_q     <= '0;
         chk_q    <= '0;
         remain_q <= '0;
         addr_q   <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         hold_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_lo_q <= len_lo_d;
         lo_q     <= lo_d;
         chk_q    <= chk_d;
         remain_q <= remain_d;
         addr_q   <= addr_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         hold_q   <= hold_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized frames checked against a frame-level model.
// Rev 1.0
`default_nettype none

module tb_program_loader;

   localparam int I_ADDR_W = 12;
   localparam int DEPTH    = 1 << I_ADDR_W;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic                imem_write_enable;
   logic [I_ADDR_W-1:0] imem_address;
   logic [15:0]         imem_write_data;
   logic                cpu_hold;
   logic                busy;
   logic                done;
   logic                error;

   int n_checks = 0;
   int n_err    = 0;

   logic [27:0] got[$];

   always #5 clk = ~clk;

   program_loader #(.INST_W(16), .I_ADDR_W(I_ADDR_W), .BYTE_W(8)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready),
      .imem_write_enable(imem_write_enable),
      .imem_address     (imem_address),
      .imem_write_data  (imem_write_data),
      .cpu_hold         (cpu_hold),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   // Every strobed cycle is one memory write.
   always @(posedge clk)
      if (imem_write_enable === 1'b1) got.push_back({imem_address, imem_write_data});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called and returns on a negedge; the posedge in between accepts the byte.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      t = 0;
      while (rx_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic all_zero(input string tag);
      check(tag, {rx_ready, imem_write_enable, imem_address, imem_write_data,
                  cpu_hold, busy, done, error}, 32'd0);
   endtask

   // chk_sel < 0 sends the correct XOR of all data bytes, otherwise the given byte.
   task automatic run_frame(input logic [15:0] words[$], input int chk_sel,
                            input bit gaps, input bit poke, input string tag);
      logic [15:0] nlen;
      logic [7:0]  x;
      logic [7:0]  chk;
      logic        ok;
      nlen = 16'(words.size());
      x    = 8'h00;
      foreach (words[i]) x = x ^ words[i][7:0] ^ words[i][15:8];
      chk  = (chk_sel < 0) ? x : chk_sel[7:0];
      ok   = (chk == x);
      got.delete();
      pulse_start();
      check({tag, "_start"}, {27'd0, busy, cpu_hold, rx_ready, done, error}, 32'b11100);
      send_byte(nlen[7:0], gaps);
      send_byte(nlen[15:8], gaps);
      for (int i = 0; i < words.size(); i++) begin
         send_byte(words[i][7:0], gaps);
         if (poke && i == 0) begin
            pulse_start();
            check({tag, "_poke"}, {29'd0, busy, rx_ready, error}, 32'b110);
         end
         send_byte(words[i][15:8], gaps);
         check({tag, "_strobe"}, {3'd0, imem_write_enable, imem_address, imem_write_data},
               {3'd0, 1'b1, i[11:0], words[i]});
      end
      send_byte(chk, gaps);
      check({tag, "_status"}, {27'd0, busy, cpu_hold, done, error, rx_ready},
            {27'd0, 1'b0, !ok, ok, !ok, 1'b0});
      check({tag, "_nwr"}, got.size(), words.size());
      for (int i = 0; i < words.size() && i < got.size(); i++)
         check({tag, "_wr"}, {4'd0, got[i]}, {4'd0, i[11:0], words[i]});
   endtask

   initial begin
      logic [15:0] wq[$];
      logic [15:0] rq[$];
      rst_n    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;

      #2 rst_n = 1'b0;
      #1 all_zero("reset_async");
      repeat (2) @(negedge clk);
      all_zero("reset_held");
      rst_n = 1'b1;
      @(negedge clk);
      all_zero("idle_after_reset");

      wq = '{16'h1234, 16'hABCD};
      run_frame(wq, -1, 1'b0, 1'b0, "normal");
      run_frame(wq, 8'h41, 1'b0, 1'b0, "badchk");

      wq.delete();
      run_frame(wq, -1, 1'b0, 1'b0, "empty_ok");
      run_frame(wq, 1, 1'b0, 1'b0, "empty_bad");

      got.delete();
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h10, 1'b0);
      check("ovf_status", {28'd0, busy, cpu_hold, done, error}, 32'b0101);
      check("ovf_ready", {31'd0, rx_ready}, 32'd0);
      repeat (3) @(negedge clk);
      check("ovf_nwr", got.size(), 0);

      wq = '{16'h1234, 16'hABCD};
      run_frame(wq, -1, 1'b1, 1'b1, "stall_poke");

      got.delete();
      pulse_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b0);
      @(negedge clk);
      check("midrst_first_wr", {4'd0, got[0]}, {4'd0, 12'h000, 16'h1234});
      #2 rst_n = 1'b0;
      #1 all_zero("midrst_zero");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(wq, -1, 1'b1, 1'b0, "reload");

      for (int f = 0; f < 6; f++) begin
         rq.delete();
         repeat ($urandom_range(1, 8)) rq.push_back(16'($urandom));
         run_frame(rq, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1,
                   1'b1, f[0], "rand");
      end

      rq.delete();
      for (int i = 0; i < DEPTH; i++) rq.push_back(16'($urandom));
      run_frame(rq, -1, 1'b0, 1'b0, "full_depth");
      check("full_last_addr", {20'd0, got[DEPTH-1][27:16]}, 32'hFFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
